// File: rtl/wb_cmd_master.sv
// Wishbone initiator: single read/write commands in, one classic Wishbone cycle each, result out.
// Optional bus-timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [31:0] adr_q, dat_q;
    logic [3:0]  sel_q;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        accept;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rsp_err_q, rsp_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        state_d   = state_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef WB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (cmd_valid) state_d = StBus;
            end
            StBus: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
`ifdef WB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = StResp;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rsp_dat_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Reads always fetch the whole word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q  <= 1'b0;
            adr_q <= 32'h0;
            dat_q <= 32'h0;
            sel_q <= 4'h0;
        end else if (accept) begin
            we_q  <= cmd_we;
            adr_q <= cmd_adr;
            dat_q <= cmd_dat;
            sel_q <= cmd_we ? cmd_sel : 4'hF;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign wbm_cyc_o = (state_q == StBus);
    assign wbm_stb_o = (state_q == StBus);
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed bring-up cases plus randomized traffic
// against a transaction-level reference model and a registered-ack multi-register slave.
module tb_wb_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    int total = 0;
    int bad   = 0;

    wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave: registers at 0x300000xx, registered ack after slave_lat extra wait cycles.
    logic [31:0] smem [64] = '{default: 32'h0};
    logic        s_ack = 1'b0;
    logic [31:0] s_rdat = 32'h0;
    int          s_cnt = 0;
    int          slave_lat = 0;
    logic [7:0]  active_project;

    assign wbm_ack_i      = s_ack;
    assign wbm_dat_i      = s_rdat;
    assign active_project = smem[0][7:0];

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && !s_ack && wbm_adr_o[31:8] == 24'h300000) begin
            if (s_cnt >= slave_lat) begin
                s_ack  <= 1'b1;
                s_cnt  <= 0;
                s_rdat <= smem[wbm_adr_o[7:2]];
                if (wbm_we_o)
                    for (int b = 0; b < 4; b++)
                        if (wbm_sel_o[b]) smem[wbm_adr_o[7:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            s_ack <= 1'b0;
            s_cnt <= 0;
        end
    end

    // Reference model: one outstanding transaction, tracked as flags plus a word memory.
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    logic        m_out, m_acked, m_we, m_rerr, acc_evt;
    logic [31:0] m_adr, m_dat, m_rdat;
    logic [3:0]  m_sel;
`ifdef WB_TIMEOUT_EN
    int          m_tcnt;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out <= 0; m_acked <= 0; m_we <= 0; m_rerr <= 0; acc_evt <= 0;
            m_adr <= 0; m_dat <= 0; m_rdat <= 0; m_sel <= 0;
`ifdef WB_TIMEOUT_EN
            m_tcnt <= 0;
`endif
        end else begin
            acc_evt <= 0;
            if (!m_out) begin
                if (cmd_valid) begin
                    m_out <= 1; m_acked <= 0; acc_evt <= 1;
                    m_we <= cmd_we; m_adr <= cmd_adr; m_dat <= cmd_dat;
                    m_sel <= cmd_we ? cmd_sel : 4'hF;
`ifdef WB_TIMEOUT_EN
                    m_tcnt <= 0;
`endif
                end
            end else if (!m_acked) begin
                if (wbm_ack_i) begin
                    m_acked <= 1;
                    m_rerr  <= 0;
                    m_rdat  <= m_we ? 32'h0 : ref_mem[m_adr[7:2]];
                    if (m_we)
                        for (int b = 0; b < 4; b++)
                            if (m_sel[b]) ref_mem[m_adr[7:2]][8*b +: 8] <= m_dat[8*b +: 8];
                end
`ifdef WB_TIMEOUT_EN
                else begin
                    m_tcnt <= m_tcnt + 1;
                    if (m_tcnt + 1 == TO) begin
                        m_acked <= 1; m_rdat <= 0; m_rerr <= 1;
                    end
                end
`endif
            end else if (rsp_ready) begin
                m_out <= 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_out));
        chk("busy", 32'(busy), 32'(m_out));
        chk("cyc", 32'(wbm_cyc_o), 32'(m_out && !m_acked));
        chk("stb_eq_cyc", 32'(wbm_stb_o), 32'(wbm_cyc_o));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_out && m_acked));
        if (m_out && !m_acked) begin
            chk("wb_we", 32'(wbm_we_o), 32'(m_we));
            chk("wb_adr", wbm_adr_o, m_adr);
            chk("wb_dat", wbm_dat_o, m_dat);
            chk("wb_sel", 32'(wbm_sel_o), 32'(m_sel));
        end
        if (m_out && m_acked) begin
            chk("rsp_dat", rsp_dat, m_rdat);
            chk("rsp_err", 32'(rsp_err), 32'(m_rerr));
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bit ok = 0;
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #2;
            if (acc_evt) ok = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    // Returns cycles from accept to rsp_valid, stb-high cycles, cmd_ready-high cycles.
    task automatic wait_rsp(output int lat, output int stbn, output int rdyn,
                            output logic [31:0] d, output logic e);
        lat = -1; stbn = 0; rdyn = 0; d = 0; e = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (wbm_stb_o) stbn++;
            if (cmd_ready) rdyn++;
            if (rsp_valid) begin
                lat = i; d = rsp_dat; e = rsp_err;
                return;
            end
        end
        chk("rsp_wait_timeout", 0, 1);
    endtask

    task automatic consume();
        rsp_ready = 1;
        @(posedge clk); #2;
        rsp_ready = 0;
    endtask

    int          lat, stbn, rdyn, acks, rsps, viol, k, hi, rv, issued;
    logic [31:0] d, held;
    logic        e, prev;

    initial begin
        reset = 0; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        rsp_ready = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_outputs", {busy, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                            wbm_sel_o}, 0);
        chk("rst_buses", wbm_adr_o | wbm_dat_o | rsp_dat, 0);
        @(posedge clk); #2 reset = 0;

        // Write project select; registered ack gives 2 stb cycles and rsp at N+3.
        issue(1, 32'h3000_0000, 32'h5, 4'hF);
        wait_rsp(lat, stbn, rdyn, d, e);
        chk("t1_latency", lat, 3);
        chk("t1_stb_cycles", stbn, 2);
        chk("t1_rsp", {e, d}, 0);
        consume();
        chk("t1_active_project", 32'(active_project), 5);

        // Read back; cmd_ready low throughout.
        issue(0, 32'h3000_0000, 32'hFFFF_FFFF, 4'h1);
        wait_rsp(lat, stbn, rdyn, d, e);
        chk("t2_rdata", d, 32'h5);
        chk("t2_err", 32'(e), 0);
        chk("t2_ready_low", rdyn, 0);

        // Backpressure: response held, new command refused.
        held = d;
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0004; cmd_dat = 32'hDEAD; cmd_sel = 4'hF;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_dat == held && !cmd_ready) hi++;
        end
        chk("t3_hold_cycles", hi, 10);
        rsp_ready = 1; cmd_valid = 0;
        @(posedge clk); #2 rsp_ready = 0;
        @(negedge clk);
        chk("t3_idle", {31'b0, cmd_ready}, 1);
        chk("t3_not_busy", {31'b0, busy | rsp_valid}, 0);

        // Back-to-back writes with everything held ready.
        @(posedge clk); #2;
        rsp_ready = 1; k = 0; acks = 0; rsps = 0; viol = 0; prev = 0;
        cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0004; cmd_dat = 32'h1111_1111;
        cmd_sel = 4'hF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbm_ack_i) acks++;
            if (rsp_valid && rsp_ready) rsps++;
            if (prev && wbm_stb_o) viol++;
            prev = wbm_ack_i;
            @(posedge clk); #2;
            if (acc_evt && cmd_valid) begin
                k++;
                if (k == 4) cmd_valid = 0;
                else cmd_dat = 32'h1111_1111 * (k + 1);
            end
        end
        rsp_ready = 0;
        chk("t4_accepts", k, 4);
        chk("t4_acks", acks, 4);
        chk("t4_rsps", rsps, 4);
        chk("t4_stb_after_ack", viol, 0);
        chk("t4_last_word", smem[1], 32'h4444_4444);

        // Unmapped read: no ack.
`ifdef WB_TIMEOUT_EN
        issue(0, 32'h3000_0300, 32'h0, 4'hF);
        wait_rsp(lat, stbn, rdyn, d, e);
        chk("t5_stb_cycles", stbn, 16);
        chk("t5_latency", lat, 17);
        chk("t5_err", 32'(e), 1);
        chk("t5_dat", d, 0);
        consume();
        issue(0, 32'h3000_0300, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
`else
        issue(0, 32'h3000_0300, 32'h0, 4'hF);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbm_stb_o && busy) hi++;
        end
        chk("t5_stuck_in_bus", hi, 40);
`endif

        // Async reset during BUS.
        @(posedge clk); #2 reset = 1;
        #1;
        chk("t6_cyc_stb", {30'b0, wbm_cyc_o, wbm_stb_o}, 0);
        chk("t6_ready", {31'b0, cmd_ready}, 1);
        chk("t6_busy", {31'b0, busy}, 0);
        repeat (2) @(posedge clk);
        #2 reset = 0; rsp_ready = 1; rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        chk("t6_no_rsp", rv, 0);
        chk("t6_ready_after", {31'b0, cmd_ready}, 1);
        rsp_ready = 0;

        // Randomized traffic.
        issued = 0;
        for (int c = 0; c < 4000 && (issued < 60 || m_out); c++) begin
            @(posedge clk); #2;
            if (acc_evt) begin
                issued++;
                cmd_valid = 0;
            end
            if (!cmd_valid && issued < 60 && $urandom_range(0, 2) != 0) begin
                cmd_we  = 1'($urandom_range(0, 1));
                cmd_adr = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
`ifdef WB_TIMEOUT_EN
                if ($urandom_range(0, 9) == 0) cmd_adr = 32'h3000_0300;
`endif
                cmd_dat   = $urandom;
                cmd_sel   = 4'($urandom_range(0, 15));
                cmd_valid = 1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            slave_lat = $urandom_range(0, 3);
        end
        cmd_valid = 0;
        chk("rand_issued", issued, 60);
        chk("rand_drained", 32'(m_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
